// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared types and helpers for the round-robin mux arbiter.
//   arb_state_t   : FSM encoding (IDLE, GRANT)
//   MAX_REQ       : upper bound on the number of requesters
//   onehot_to_idx : converts a one-hot vector (MAX_REQ wide) to its bit index
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = $clog2(MAX_REQ);

  // OR-reduction form keeps this a flat mux tree; a zero vector maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if
// Request/grant bundle between N requesters and the mux arbiter.
//   req       : request vector, one bit per requester (requester side drives)
//   gnt       : one-hot or zero grant vector (arbiter drives)
//   sel       : mux select, index of current or last owner (arbiter drives)
//   sel_valid : high while some requester owns the mux (arbiter drives)
//   busy      : high while the arbiter FSM is in GRANT (arbiter drives)
// Modports: master = requester side, slave = arbiter side.
interface mux_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int SEL_W = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             busy;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  sel_valid,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output sel_valid,
    output busy
  );

endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick
// Purely combinational round-robin picker.
//   req  : request vector
//   last : index of the last owner
//   pick : first requester at or above (last + 1) mod N_REQ, with wrap-around
//   any  : high when any request bit is set
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [N_REQ-1:0]   hi_oh;
  logic [N_REQ-1:0]   lo_oh;
  logic [MAX_REQ-1:0] pick_oh;

  // Scanning downward lets the lowest matching index overwrite the others.
  // hi_oh holds the first request above the last owner; lo_oh holds the
  // lowest request overall, used when the search has to wrap around.
  always_comb begin
    hi_oh   = '0;
    lo_oh   = '0;
    pick_oh = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_oh    = '0;
        lo_oh[i] = 1'b1;
        if (i > int'(last)) begin
          hi_oh    = '0;
          hi_oh[i] = 1'b1;
        end
      end
    end
    pick_oh[N_REQ-1:0] = (|hi_oh) ? hi_oh : lo_oh;
  end

  assign pick = SEL_W'(onehot_to_idx(pick_oh));
  assign any  = |req;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter
// Round-robin arbiter owning the select line of a shared N:1 mux.
// Grants are held while the owner keeps requesting; on release the next
// requester is handed the mux at the same edge.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_arbiter_if.slave (req in; gnt, sel, sel_valid, busy out)
// Optional feature: define MUX_ARB_BURST_LIMIT_EN to force rotation after
// MAX_BURST consecutive grant cycles while other requesters are waiting.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 8,
  parameter int SEL_W     = $clog2(N_REQ)
) (
  input logic         clk,
  input logic         rst_n,
  mux_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("mux_arbiter: parameter out of range");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             others;
  logic             rotate;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick_idx),
    .any  (pick_any)
  );

  assign owner_req = bus.req[last_q];
  assign others    = |(bus.req & ~gnt_q);

`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [7:0] burst_q, burst_d;

  // The current grant cycle counts toward the burst, so the owner gets
  // exactly MAX_BURST cycles before a waiting requester takes over.
  assign rotate = ({1'b0, burst_q} + 9'd1 >= 9'(MAX_BURST)) && others;
`else
  assign rotate = 1'b0;
`endif

  // Next-state logic: IDLE grants any request, GRANT holds, hands over
  // directly to the next pick, or falls back to IDLE keeping sel.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
`ifdef MUX_ARB_BURST_LIMIT_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          sel_d   = pick_idx;
          last_d  = pick_idx;
`ifdef MUX_ARB_BURST_LIMIT_EN
          burst_d = '0;
`endif
        end
      end
      GRANT: begin
        if (owner_req && !rotate) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
          burst_d = (burst_q >= 8'(MAX_BURST)) ? burst_q : burst_q + 8'd1;
`endif
        end else if (others) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          sel_d   = pick_idx;
          last_d  = pick_idx;
`ifdef MUX_ARB_BURST_LIMIT_EN
          burst_d = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Last-owner pointer resets to N_REQ-1 so requester 0 is picked first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
`ifdef MUX_ARB_BURST_LIMIT_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef MUX_ARB_BURST_LIMIT_EN
      burst_q <= burst_d;
`endif
    end
  end

  // sel_valid and busy decode the state flop only; GRANT always has one gnt bit.
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = (state_q == GRANT);
  assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter
// Directed self-checking bench for mux_arbiter with N_REQ = 4, MAX_BURST = 3.
// Expected grant/select values are queued when a request pattern is driven
// and popped after the following clock edge.
module tb_mux_arbiter;

  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 3;
  localparam int SEL_W     = 2;

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef struct {
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    string            tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  mux_arbiter_if #(.N_REQ(N_REQ)) bus ();

  mux_arbiter #(
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".gnt"}, 32'(bus.gnt), 32'(e.gnt));
      check({e.tag, ".sel"}, 32'(bus.sel), 32'(e.sel));
      check({e.tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(e.gnt != '0));
      check({e.tag, ".busy"}, 32'(bus.busy), 32'(e.gnt != '0));
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] eg,
                               input logic [SEL_W-1:0] es, input string tag);
    exp_t e;
    bus.req = r;
    e.gnt   = eg;
    e.sel   = es;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.req = 4'b0011;

    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt", 32'(bus.gnt), 32'h0);
    check("rst.sel", 32'(bus.sel), 32'h0);
    check("rst.sel_valid", 32'(bus.sel_valid), 32'h0);
    check("rst.busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;

    $display("[TB] reset release and handover");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "rel_grant");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "hold1");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "hold2");
    applyStimulus(4'b0010, 4'b0010, 2'd1, "handover");

    $display("[TB] idle hold");
    applyStimulus(4'b0010, 4'b0010, 2'd1, "own1");
    applyStimulus(4'b0000, 4'b0000, 2'd1, "idle1");
    applyStimulus(4'b0000, 4'b0000, 2'd1, "idle2");
    applyStimulus(4'b0001, 4'b0001, 2'd0, "regrant0");
    applyStimulus(4'b0000, 4'b0000, 2'd0, "idle3");

    $display("[TB] mid-grant reset");
    applyStimulus(4'b0010, 4'b0010, 2'd1, "mg_grant");
    bus.req = 4'b0011;
    #2;
    rst_n = 1'b0;
    #1;
    check("mg_rst.gnt", 32'(bus.gnt), 32'h0);
    check("mg_rst.sel", 32'(bus.sel), 32'h0);
    check("mg_rst.sel_valid", 32'(bus.sel_valid), 32'h0);
    check("mg_rst.busy", 32'(bus.busy), 32'h0);
    #2;
    rst_n = 1'b1;
    applyStimulus(4'b0011, 4'b0001, 2'd0, "mg_win0");

    $display("[TB] round robin");
    applyStimulus(4'b1110, 4'b0010, 2'd1, "rr1");
    applyStimulus(4'b1101, 4'b0100, 2'd2, "rr2");
    applyStimulus(4'b1011, 4'b1000, 2'd3, "rr3");
    applyStimulus(4'b0111, 4'b0001, 2'd0, "rr0");

    $display("[TB] burst limit");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "b1");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "b2");
    applyStimulus(4'b0011, BURST_EN ? 4'b0010 : 4'b0001, BURST_EN ? 2'd1 : 2'd0, "b3");
    applyStimulus(4'b0011, BURST_EN ? 4'b0010 : 4'b0001, BURST_EN ? 2'd1 : 2'd0, "b4");
    applyStimulus(4'b0011, BURST_EN ? 4'b0010 : 4'b0001, BURST_EN ? 2'd1 : 2'd0, "b5");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "b6");
    applyStimulus(4'b0011, 4'b0001, 2'd0, "b7");

    $display("[TB] burst saturation");
    applyStimulus(4'b0001, 4'b0001, 2'd0, "s1");
    applyStimulus(4'b0001, 4'b0001, 2'd0, "s2");
    applyStimulus(4'b0001, 4'b0001, 2'd0, "s3");
    applyStimulus(4'b0001, 4'b0001, 2'd0, "s4");
    applyStimulus(4'b0011, BURST_EN ? 4'b0010 : 4'b0001, BURST_EN ? 2'd1 : 2'd0, "s5");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares one N:1 `mux` between N requesters and drives its select line. It sits directly in front of the `mux` instance and owns `mux_select`. Its select output is always a registered, known value, never X or Z, so the mux never falls into its X default arm. Grants are held until released, with an optional burst limit for fairness.

## Interface
- `N_REQ`, default 2: number of requesters; legal range 2..16.
- `MAX_BURST`, default 8: maximum consecutive grant cycles before forced rotation; legal range 1..255. Used only with the burst-limit feature.
- `SEL_W`, default `$clog2(N_REQ)`: width of `sel`. Derived; must not be overridden.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, N_REQ: request vector; bit i high means requester i wants the mux.
- `gnt`, output, N_REQ: registered grant, one-hot or zero.
- `sel`, output, SEL_W: registered mux select. Equals the index of the current or last owner.
- `sel_valid`, output, 1: high when `gnt` is non-zero, i.e. the mux output is owned.
- `busy`, output, 1: high when the FSM is in GRANT.

## Operation
- FSM has two states: IDLE and GRANT. The state encoding lives in the package.
- Reset values:
  - state = IDLE, `gnt` = 0, `sel` = 0, `sel_valid` = 0, `busy` = 0.
  - Last-owner pointer = N_REQ-1, so requester 0 has first priority.
  - Burst counter = 0.
- Pick rule: the first set bit of `req` searching upward from (last owner + 1) mod N_REQ, with wrap-around.
- IDLE:
  - If `req` is non-zero, go to GRANT with the picked requester. Load `gnt`, `sel` and the last-owner pointer; clear the burst counter.
  - Otherwise stay in IDLE.
- GRANT, owner k:
  - `req[k]` = 1 and no rotation forced: hold `gnt`/`sel`; increment the burst counter.
  - `req[k]` = 0 and other requests pending: hand over directly to the picked requester, with no idle bubble.
  - `req[k]` = 0 and no requests pending: go to IDLE. `gnt` becomes 0; `sel` keeps k.
- `sel` changes only when a new grant is issued. In IDLE it keeps its last value, so the mux output stays defined.
- Simultaneous requests are resolved by the pick rule only; there are no fixed priorities after reset.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous). Requesters must re-arbitrate.
- Requests that are not granted are not latched; a requester must hold `req` until it sees `gnt`.

## Timing
- Latency from `req` to `gnt` is 1 cycle. `req` sampled high at edge t gives `gnt` high after edge t.
- Release takes 1 cycle: `req[k]` sampled low at edge t gives `gnt[k]` = 0 after edge t. The next owner, if any, is granted at the same edge.
- `sel` and `gnt` update on the same edge; there is never a cycle where `gnt[i]` = 1 and `sel` ≠ i.
- All outputs are flops; there are no combinational paths from `req` to the outputs.

## Configuration
- `MUX_ARB_BURST_LIMIT_EN` defined:
  - The burst counter counts grant cycles for the current owner.
  - When the count reaches MAX_BURST and any other `req` bit is set, the next edge rotates the grant to the picked requester, even if the owner still requests.
  - If no other requester is pending, the grant is held and the counter saturates at MAX_BURST.
- `MUX_ARB_BURST_LIMIT_EN` undefined: the burst counter is not built; a grant is held for as long as the owner's `req` stays high.

## Structure
- Package `mux_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, GRANT);
  - the `MAX_REQ` = 16 limit constant;
  - a `onehot_to_idx` function.
- Sub-module `rr_pick`: purely combinational. It takes `req` and the last-owner pointer and returns the pick index plus an `any` flag. The FSM and flops stay in `mux_arbiter`.
- `mux_arbiter` instantiates the existing `mux` only in the bench, not internally.

## Test plan
- **Reset state.** Assert `rst_n` = 0 with `req` = 2'b11 → `gnt` = 0, `sel` = 0, `sel_valid` = 0, `busy` = 0. Release reset → `gnt` = 2'b01, `sel` = 0 one cycle later.
- **Handover.** Owner 0 holds for 4 cycles with `req` = 2'b11, then drops `req[0]` → at the next edge `gnt` = 2'b10 and `sel` = 1, with no zero-grant cycle.
- **Idle hold.** With `req` = 2'b10 granted, drop to `req` = 0 → `gnt` = 0, `busy` = 0, `sel` stays 1. Re-raise `req` = 2'b01 → `gnt` = 2'b01, `sel` = 0.
- **Round robin.** N_REQ = 4, all requesters hold 1 cycle then release and re-request repeatedly → grant order 0, 1, 2, 3, 0.
- **Burst limit.** With `MUX_ARB_BURST_LIMIT_EN`, MAX_BURST = 3, `req` = 2'b11 held → `gnt` alternates 01, 01, 01, 10, 10, 10, … With the macro undefined → `gnt` stays 01.
- **Mid-grant reset.** Pulse `rst_n` low asynchronously while `gnt` = 2'b10 → outputs clear before the next clock edge, and requester 0 wins afterwards.
